// File: rtl/jk_drive_pkg.sv
// jk_drive_pkg
// Shared types and constants for the JK drive controller slice.
//   state_t    : controller FSM states (IDLE, DRIVE, CHECK)
//   EXC_SR     : excitation style where J and K are never both high
//   EXC_TOGGLE : excitation style where every changing bit gets J=K=1
//   sat_cnt2   : squeezes an internal retry count into the 2-bit report
package jk_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int EXC_SR     = 0;
  localparam int EXC_TOGGLE = 1;

  // The external retry counter is only 2 bits wide; larger internal counts
  // stick at 3 instead of wrapping.
  function automatic logic [1:0] sat_cnt2(input logic [7:0] n);
    return (n > 8'd3) ? 2'd3 : n[1:0];
  endfunction

endpackage

// File: rtl/jk_drive_ctrl_if.sv
// jk_drive_ctrl_if
// Target-word handshake between a producer of target states and the
// JK drive controller.
//   tgt_valid : producer has a target word
//   tgt_ready : controller can accept a target word
//   tgt_data  : WIDTH-bit target state for the flop bank
// modport master : producer side
// modport slave  : controller side
interface jk_drive_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);

endinterface

// File: rtl/jk_excite.sv
// jk_excite
// Purely combinational JK excitation for a whole word: the J/K values that
// move flops currently at q to the state t in one clock.
//   q    : current flop outputs
//   t    : wanted flop outputs
//   mode : EXC_SR or EXC_TOGGLE resolution of the don't-care inputs
//   j, k : excitation word
module jk_excite
  import jk_drive_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [WIDTH-1:0] diff;

  // Bits that already hold their target get J=K=0. A changing bit either
  // toggles (J=K=1) or is explicitly set/reset depending on the mode.
  always_comb begin
    diff = q ^ t;
    if (mode == 1'(EXC_TOGGLE)) begin
      j = diff;
      k = diff;
    end else begin
      j = diff & t;
      k = diff & q;
    end
  end

endmodule

// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl
// Drive-side controller for a bank of WIDTH JK flops. Accepts a target word,
// issues one cycle of J/K excitation, checks the readback and re-drives up to
// MAX_RETRY times before giving up.
//   clk       : clock, all state changes on posedge
//   rst       : asynchronous reset, active low
//   tgt       : target handshake (slave side)
//   abort     : synchronous abort of the current operation
//   q_in      : readback of the flop bank outputs
//   j_out     : J drive to the flop bank
//   k_out     : K drive to the flop bank
//   busy      : controller is not idle
//   done      : one-cycle pulse, target reached
//   err       : one-cycle pulse, retries exhausted or aborted
//   retry_cnt : re-drives used by the last or current operation
module jk_drive_ctrl
  import jk_drive_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int EXC_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  jk_drive_ctrl_if.slave   tgt,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retry_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [7:0]       rtry_q, rtry_d;
  logic [WIDTH-1:0] j_d, k_d;
  logic             done_d, err_d;
  logic [WIDTH-1:0] exc_t, exc_j, exc_k;

  // One excitation unit serves both the initial drive (fresh target from the
  // handshake) and every re-drive (latched target).
  assign exc_t = (state_q == IDLE) ? tgt.tgt_data : tgt_q;

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .q    (q_in),
    .t    (exc_t),
    .mode (1'(EXC_MODE)),
    .j    (exc_j),
    .k    (exc_k)
  );

  // Next-state and next-output logic. J/K default to zero so they are only
  // non-zero during the single DRIVE cycle that follows a load. Abort wins
  // over a simultaneous match in CHECK.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rtry_d  = rtry_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt.tgt_valid && tgt.tgt_ready) begin
          tgt_d   = tgt.tgt_data;
          rtry_d  = 8'd0;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (q_in == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (rtry_q < 8'(MAX_RETRY)) begin
          rtry_d  = rtry_q + 8'd1;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. busy and tgt_ready are registered copies of
  // the next state so every output comes straight from a flop; tgt_ready
  // stays low for the whole reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      rtry_q        <= 8'd0;
      j_out         <= '0;
      k_out         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      retry_cnt     <= 2'd0;
      tgt.tgt_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      rtry_q        <= rtry_d;
      j_out         <= j_d;
      k_out         <= k_d;
      done          <= done_d;
      err           <= err_d;
      busy          <= (state_d != IDLE);
      retry_cnt     <= sat_cnt2(rtry_d);
      tgt.tgt_ready <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb_jk_drive_ctrl
// Directed bench for jk_drive_ctrl. Two controllers (set/reset and toggle
// excitation) share one target handshake and drive separate JK bank models.
// Expected results are queued when a target is presented and retired when
// the controller pulses done or err.
module tb_jk_drive_ctrl;

  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] j1;
    logic [3:0] k1;
    int         lat;
    int         drives;
    logic       done;
    logic       err;
    logic [1:0] rc;
    bit         chk1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort0, abort1;
  logic [3:0] q0, q1, j0, k0, j1, k1;
  logic       busy0, done0, err0, busy1, done1, err1;
  logic [1:0] rc0, rc1;
  logic       bank_load;
  logic [3:0] bank_val, stuck0;
  logic [3:0] rq, rt, rj, rk;
  logic       rm;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  jk_drive_ctrl_if #(.WIDTH(4)) if0 ();
  jk_drive_ctrl_if #(.WIDTH(4)) if1 ();

  assign if1.tgt_valid = if0.tgt_valid;
  assign if1.tgt_data  = if0.tgt_data;

  always #5 clk = ~clk;

  jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(2), .EXC_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .tgt(if0), .abort(abort0), .q_in(q0),
    .j_out(j0), .k_out(k0), .busy(busy0), .done(done0), .err(err0),
    .retry_cnt(rc0)
  );

  jk_drive_ctrl #(.WIDTH(4), .MAX_RETRY(2), .EXC_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .tgt(if1), .abort(abort1), .q_in(q1),
    .j_out(j1), .k_out(k1), .busy(busy1), .done(done1), .err(err1),
    .retry_cnt(rc1)
  );

  jk_excite #(.WIDTH(4)) u_ref (.q(rq), .t(rt), .mode(rm), .j(rj), .k(rk));

  // Next state of a JK flop word: hold, reset, set or toggle per bit.
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  // Excitation table written out bit by bit: returns {j, k}.
  function automatic logic [7:0] excite_ref(input logic [3:0] q, input logic [3:0] t,
                                            input bit mode);
    logic [3:0] j, k;
    for (int i = 0; i < 4; i++) begin
      case ({q[i], t[i]})
        2'b01:   begin j[i] = 1'b1;  k[i] = mode; end
        2'b10:   begin j[i] = mode;  k[i] = 1'b1; end
        default: begin j[i] = 1'b0;  k[i] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] q, input logic [3:0] t,
                                  input int lat, input int drives, input logic dn,
                                  input logic er, input logic [1:0] rc, input bit chk1);
    exp_t e;
    logic [7:0] e0, e1;
    e0 = excite_ref(q, t, 1'b0);
    e1 = excite_ref(q, t, 1'b1);
    e.j = e0[7:4];  e.k = e0[3:0];
    e.j1 = e1[7:4]; e.k1 = e1[3:0];
    e.lat = lat; e.drives = drives; e.done = dn; e.err = er; e.rc = rc; e.chk1 = chk1;
    return e;
  endfunction

  // Bank models: bank 0 can have bits stuck at zero; both can be preloaded.
  always @(posedge clk) begin
    if (bank_load) begin
      q0 <= bank_val;
      q1 <= bank_val;
    end else begin
      q0 <= jk_next(q0, j0, k0) & ~stuck0;
      q1 <= jk_next(q1, j1, k1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic setBank(input logic [3:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    @(posedge clk);
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Presents a target at the current negedge; returns at the negedge of the
  // first cycle after the accepting edge.
  task automatic applyStimulus(input logic [3:0] t, input bit push, input exp_t e);
    checkOutput("ready_before_accept", if0.tgt_ready, 1);
    if0.tgt_valid = 1'b1;
    if0.tgt_data  = t;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if0.tgt_valid = 1'b0;
    if0.tgt_data  = 4'h0;
  endtask

  // Follows one operation cycle by cycle from the DRIVE cycle until done or
  // err, then retires the oldest expectation against what was seen.
  task automatic waitResult(input int budget, input int abort_at);
    exp_t e;
    int   lat = 0;
    int   drives = 0;
    bit   seen = 0;
    e = sb.pop_front();
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        checkOutput("drive_j", j0, e.j);
        checkOutput("drive_k", k0, e.k);
        checkOutput("busy_in_drive", busy0, 1);
        checkOutput("ready_in_drive", if0.tgt_ready, 0);
        if (e.chk1) begin
          checkOutput("toggle_drive_j", j1, e.j1);
          checkOutput("toggle_drive_k", k1, e.k1);
        end
      end
      if (c == 2) begin
        checkOutput("j_cleared_in_check", j0, 0);
        checkOutput("k_cleared_in_check", k0, 0);
      end
      if ((j0 | k0) != 4'h0) drives++;
      abort0 = (abort_at == c);
      if (done0 || err0) begin
        seen = 1;
        lat  = c;
        break;
      end
    end
    abort0 = 1'b0;
    checkOutput("result_seen", seen, 1);
    if (seen) begin
      checkOutput("latency", lat, e.lat);
      checkOutput("done", done0, e.done);
      checkOutput("err", err0, e.err);
      checkOutput("retry_cnt", rc0, e.rc);
      checkOutput("drive_count", drives, e.drives);
      checkOutput("ready_at_result", if0.tgt_ready, 1);
      checkOutput("busy_at_result", busy0, 0);
      checkOutput("j_idle", j0, 0);
      checkOutput("k_idle", k0, 0);
      if (e.chk1) checkOutput("toggle_done", done1, e.done);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    rst = 1'b0;
    abort0 = 1'b0;
    abort1 = 1'b0;
    if0.tgt_valid = 1'b0;
    if0.tgt_data  = 4'h0;
    bank_load = 1'b0;
    bank_val  = 4'h0;
    stuck0    = 4'h0;

    // Reset values
    #12;
    checkOutput("rst_j", j0, 0);
    checkOutput("rst_k", k0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_err", err0, 0);
    checkOutput("rst_retry_cnt", rc0, 0);
    checkOutput("rst_ready", if0.tgt_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", if0.tgt_ready, 1);
    checkOutput("toggle_ready_after_rst", if1.tgt_ready, 1);

    // Abort while idle does nothing
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    checkOutput("idle_abort_busy", busy0, 0);
    checkOutput("idle_abort_err", err0, 0);

    // 1100 -> 0101 in both excitation styles
    setBank(4'b1100);
    e = mk_exp(4'b1100, 4'b0101, 3, 1, 1'b1, 1'b0, 2'd0, 1'b1);
    applyStimulus(4'b0101, 1'b1, e);
    waitResult(10, 0);
    checkOutput("sr_bank_q", q0, 4'b0101);
    checkOutput("toggle_bank_q", q1, 4'b0101);

    // 0000 -> 1010 set/reset style
    setBank(4'b0000);
    e = mk_exp(4'b0000, 4'b1010, 3, 1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b1010, 1'b1, e);
    waitResult(10, 0);
    checkOutput("bank_q_1010", q0, 4'b1010);

    // Bit 0 stuck low: three drives, then err with retries exhausted
    setBank(4'b0000);
    stuck0 = 4'b0001;
    e = mk_exp(4'b0000, 4'b0001, 7, 3, 1'b0, 1'b1, 2'd2, 1'b0);
    applyStimulus(4'b0001, 1'b1, e);
    waitResult(12, 0);
    stuck0 = 4'b0000;
    @(negedge clk);
    checkOutput("retry_cnt_holds", rc0, 2);

    // Target already reached, then a second target in the done cycle
    setBank(4'b0110);
    e = mk_exp(4'b0110, 4'b0110, 3, 0, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b0110, 1'b1, e);
    waitResult(10, 0);
    e = mk_exp(4'b0110, 4'b1001, 3, 1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b1001, 1'b1, e);
    waitResult(10, 0);
    checkOutput("bank_q_1001", q0, 4'b1001);

    // Abort in CHECK while the readback already matches
    e = mk_exp(4'b1001, 4'b0011, 3, 1, 1'b0, 1'b1, 2'd0, 1'b0);
    applyStimulus(4'b0011, 1'b1, e);
    waitResult(10, 2);
    checkOutput("abort_bank_q", q0, 4'b0011);

    // Reset pulled mid-DRIVE
    e = mk_exp(4'b0011, 4'b1111, 3, 1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b0, e);
    checkOutput("busy_before_rst", busy0, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_j", j0, 0);
    checkOutput("midrst_k", k0, 0);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_ready", if0.tgt_ready, 0);
    @(negedge clk);
    checkOutput("midrst_done", done0, 0);
    checkOutput("midrst_err", err0, 0);
    checkOutput("midrst_ready_held", if0.tgt_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", if0.tgt_ready, 1);
    checkOutput("post_rst_busy", busy0, 0);
    checkOutput("post_rst_done", done0, 0);
    checkOutput("post_rst_err", err0, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    // Excitation unit against the written-out table
    for (int i = 0; i < 8; i++) begin
      logic [7:0] r;
      rq = 4'($urandom);
      rt = 4'($urandom);
      rm = 1'(i & 1);
      #1;
      r = excite_ref(rq, rt, rm);
      checkOutput("excite_jk", {rj, rk}, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
